// File: rtl/pwm_pkg.sv
// Shared types and result mapping for the PWM duty meter.
// Build option: PWM_DEGLITCH_EN (see pwm_duty_meter).
package pwm_pkg;

  localparam int DEF_WIN_BITS = 8;
  // Wide enough for any supported WIN_BITS (up to 15).
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    FLUSH,
    ACQUIRE,
    TRACK
  } state_t;

  // Returns {no_signal, duty}; duty is high_count-1, zero when no high cycles were seen.
  function automatic logic [RES_W:0] map_result(input logic [RES_W:0] r);
    if (r == '0) begin
      map_result = {1'b1, {RES_W{1'b0}}};
    end else begin
      map_result = {1'b0, r[RES_W-1:0] - RES_W'(1)};
    end
  endfunction

endpackage

// File: rtl/pwm_duty_meter_sync.sv
// Multi-flop bit synchronizer with asynchronous clear; generic, reusable.
module pwm_in_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p0[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_duty_meter.sv
// Recovers the 8-bit PWM intensity code by counting high cycles per aligned window.
// Build option: define PWM_DEGLITCH_EN to add a 3-tap majority filter after the synchronizer.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int WIN_BITS    = DEF_WIN_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                pwm_in,
  output logic [WIN_BITS-1:0] duty,
  output logic                duty_valid,
  output logic                locked,
  output logic                no_signal
);

  logic s;
  logic smp;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (pwm_in),
    .q   (s)
  );

`ifdef PWM_DEGLITCH_EN
  // Majority of the current and two previous samples removes 1-cycle pulses and dropouts.
  logic [1:0] dg_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dg_p1 <= '0;
    end else begin
      dg_p1 <= {dg_p1[0], s};
    end
  end

  assign smp = (s & dg_p1[0]) | (s & dg_p1[1]) | (dg_p1[0] & dg_p1[1]);
`else
  assign smp = s;
`endif

  logic [WIN_BITS-1:0] wcnt;
  logic [WIN_BITS:0]   hcnt;
  logic [WIN_BITS:0]   hcnt_final;
  logic [WIN_BITS:0]   prev;
  logic [RES_W:0]      res;
  logic                terminal;
  logic                publish;
  logic                unused_res_hi;
  state_t              state;
  state_t              state_d;

  // The terminal cycle's own sample belongs to the closing window.
  assign terminal      = en && (wcnt == '1);
  assign hcnt_final    = hcnt + {{WIN_BITS{1'b0}}, smp};
  assign res           = map_result({{(RES_W-WIN_BITS){1'b0}}, hcnt_final});
  assign unused_res_hi = ^res[RES_W-1:WIN_BITS];

  always_comb begin
    state_d = state;
    publish = 1'b0;
    if (!en) begin
      state_d = FLUSH;
    end else if (terminal) begin
      case (state)
        FLUSH:   state_d = ACQUIRE;
        ACQUIRE: begin
          state_d = TRACK;
          publish = 1'b1;
        end
        TRACK:   publish = 1'b1;
        default: state_d = FLUSH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FLUSH;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt       <= '0;
      hcnt       <= '0;
      prev       <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
      no_signal  <= 1'b0;
    end else if (!en) begin
      wcnt       <= '0;
      hcnt       <= '0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      wcnt       <= wcnt + WIN_BITS'(1);
      hcnt       <= terminal ? '0 : hcnt_final;
      duty_valid <= publish;
      if (publish) begin
        duty      <= res[WIN_BITS-1:0];
        no_signal <= res[RES_W];
        prev      <= hcnt_final;
        locked    <= (state == TRACK) && (hcnt_final == prev);
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter driven by a behavioural PWM generator.
module tb_pwm_duty_meter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       en;
  logic [7:0] duty;
  logic       duty_valid;
  logic       locked;
  logic       no_signal;

  logic [7:0] gcnt  = 8'd0;
  logic [7:0] phase = 8'd0;
  logic [7:0] code  = 8'd0;
  logic [1:0] mode  = 2'd0;   // 0: generator, 1: held low, 2: held high
  logic       pwm_in;

  int n_chk  = 0;
  int n_pass = 0;

  pwm_duty_meter dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .locked     (locked),
    .no_signal  (no_signal)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) gcnt <= gcnt + 8'd1;

  assign pwm_in = (mode == 2'd1) ? 1'b0 :
                  (mode == 2'd2) ? 1'b1 :
                  (code >= 8'(gcnt + phase));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!duty_valid && n < 700);
    if (!duty_valid) chk("valid_timeout", 0, 1);
  endtask

  function automatic int exp_duty(input logic [7:0] c);
`ifdef PWM_DEGLITCH_EN
    if (c == 8'h00) return 0;
    if (c == 8'hFE) return 'hFF;
`endif
    return int'(c);
  endfunction

  function automatic int exp_ns(input logic [7:0] c);
`ifdef PWM_DEGLITCH_EN
    return (c == 8'h00) ? 1 : 0;
`else
    return (c == 8'h00) ? 0 : 0;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] codes [4];
    int n;
    codes[0] = 8'h00; codes[1] = 8'h01; codes[2] = 8'hFE; codes[3] = 8'hFF;

    RST = 1'b1; en = 1'b0; code = 8'h7F; mode = 2'd0; phase = 8'd0;
    repeat (3) step();
    RST = 1'b0;
    chk("rst_duty", int'(duty), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_nosig", int'(no_signal), 0);

    en = 1'b1;
    wait_valid(n);
    chk("first_lat", n, 512);
    chk("first_duty", int'(duty), 'h7F);
    chk("first_locked", int'(locked), 0);
    chk("first_nosig", int'(no_signal), 0);
    wait_valid(n);
    chk("track_period", n, 256);
    chk("track_duty", int'(duty), 'h7F);
    chk("track_locked", int'(locked), 1);

    en = 1'b0;
    step();
    chk("enlow_locked", int'(locked), 0);
    phase = 8'($urandom_range(1, 255));
    en = 1'b1;
    wait_valid(n);
    chk("phase_lat", n, 512);
    chk("phase_duty", int'(duty), 'h7F);
    chk("phase_locked0", int'(locked), 0);
    wait_valid(n);
    chk("phase_duty2", int'(duty), 'h7F);
    chk("phase_locked1", int'(locked), 1);

    foreach (codes[k]) begin
      code = codes[k];
      wait_valid(n);
      for (int i = 0; i < 3; i++) begin
        wait_valid(n);
        chk("code_period", n, 256);
        chk("code_duty", int'(duty), exp_duty(codes[k]));
        chk("code_nosig", int'(no_signal), exp_ns(codes[k]));
        if (i > 0) chk("code_locked", int'(locked), 1);
      end
    end

    mode = 2'd1;
    wait_valid(n);
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      chk("low_duty", int'(duty), 0);
      chk("low_nosig", int'(no_signal), 1);
      if (i > 0) chk("low_locked", int'(locked), 1);
    end
    mode = 2'd2;
    wait_valid(n);
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      chk("high_duty", int'(duty), 'hFF);
      chk("high_nosig", int'(no_signal), 0);
      if (i > 0) chk("high_locked", int'(locked), 1);
    end

    mode = 2'd0;
    code = 8'h40;
    repeat (3) wait_valid(n);
    chk("c40_duty", int'(duty), 'h40);
    chk("c40_locked", int'(locked), 1);
    repeat (97) step();
    code = 8'hC0;
    wait_valid(n);
    chk("mix_lat", n, 159);
    chk("mix_locked", int'(locked), 0);
    wait_valid(n);
    chk("c0_duty", int'(duty), 'hC0);
    chk("c0_locked0", int'(locked), 0);
    wait_valid(n);
    chk("c0_duty2", int'(duty), 'hC0);
    chk("c0_locked1", int'(locked), 1);

    repeat (100) step();
    RST = 1'b1;
    #1;
    chk("arst_duty", int'(duty), 0);
    chk("arst_valid", int'(duty_valid), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_nosig", int'(no_signal), 0);
    RST = 1'b0;
    wait_valid(n);
    chk("rstrel_lat", n, 512);
    chk("rstrel_duty", int'(duty), 'hC0);
    chk("rstrel_locked", int'(locked), 0);
    wait_valid(n);
    chk("rstrel_locked1", int'(locked), 1);

    repeat (50) step();
    en = 1'b0;
    step();
    chk("endrop_locked", int'(locked), 0);
    chk("endrop_duty", int'(duty), 'hC0);
    chk("endrop_nosig", int'(no_signal), 0);
    repeat (9) step();
    chk("endrop_hold", int'(duty), 'hC0);
    en = 1'b1;
    wait_valid(n);
    chk("enret_lat", n, 512);
    chk("enret_duty", int'(duty), 'hC0);
    chk("enret_locked", int'(locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
